// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, registered sync/active levels and line/frame/vblank pulses.
// Optional feature macro VGA_FRAME_CNT_EN adds an 8-bit wrapping frame counter output (frame_cnt_o).
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 783,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 31,
  parameter int unsigned V_ACT_END   = 510
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  output logic       pix_tick_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       active_o,
  output logic       line_start_o,
  output logic       frame_start_o,
  output logic       vblank_start_o
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt_o
`endif
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0]       V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0]       H_ACT_LO = 10'(H_ACT_START);
  localparam logic [9:0]       H_ACT_HI = 10'(H_ACT_END);
  localparam logic [9:0]       V_ACT_LO = 10'(V_ACT_START);
  localparam logic [9:0]       V_ACT_HI = 10'(V_ACT_END);
  localparam logic [9:0]       VBL_LINE = 10'(V_ACT_END + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             active_q, active_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             vblank_q, vblank_d;

  assign pix_tick_o = enable_i && (div_q == DIV_LAST);

  // Levels are derived from the next-state counters so they never lag hcount/vcount.
  always_comb begin
    div_d    = div_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    line_d   = 1'b0;
    frame_d  = 1'b0;
    vblank_d = 1'b0;
    if (pix_tick_o) begin
      div_d = '0;
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        line_d   = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d = '0;
          frame_d  = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
        vblank_d = (vcount_d == VBL_LINE);
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end else if (enable_i) begin
      div_d = div_q + 1'b1;
    end
    hs_d     = (hcount_d >= H_SYNC_W);
    vs_d     = (vcount_d >= V_SYNC_W);
    active_d = (hcount_d >= H_ACT_LO) && (hcount_d <= H_ACT_HI) &&
               (vcount_d >= V_ACT_LO) && (vcount_d <= V_ACT_HI);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      active_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
    end
  end

  assign hcount_o       = hcount_q;
  assign vcount_o       = vcount_q;
  assign hs_o           = hs_q;
  assign vs_o           = vs_q;
  assign active_o       = active_q;
  assign line_start_o   = line_q;
  assign frame_start_o  = frame_q;
  assign vblank_start_o = vblank_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Steps on the same edge that raises frame_start, so the new count is seen with the pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cnt_q <= '0;
    end else if (frame_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
